// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types: transfer encodings, response codes and slave FSM states.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ahb_slv_state_t;

endpackage

// File: rtl/ahb_access_check.sv
// Address-phase decode: word index and legality of a read (write, range, size, alignment).
module ahb_access_check #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    output logic [SEL_W-1:0]  idx,
    output logic              err
);

    localparam int BYTE_SHIFT = $clog2(DATA_W / 8);

    logic [ADDR_W-1:0] idx_full;
    logic              misaligned;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        idx_full   = haddr >> BYTE_SHIFT;
        misaligned = 1'b0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (haddr[i] && (i < int'(hsize))) begin
                misaligned = 1'b1;
            end
        end
        err = hwrite
            | ({1'b0, idx_full} >= (ADDR_W + 1)'(NUM_REGS))
            | (hsize > 3'(BYTE_SHIFT))
            | misaligned;
        idx = idx_full[SEL_W-1:0];
    end

endmodule

// File: rtl/ahb_read_slave.sv
// AHB-Lite read-only status slave with configurable wait states, ERROR response
// for illegal accesses and a per-word read strobe for clear-on-read owners.
module ahb_read_slave
    import ahb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                       hclk,
    input  logic                       hreset_n,
    input  logic                       hsel,
    input  logic [ADDR_W-1:0]          haddr,
    input  logic [1:0]                 htrans,
    input  logic                       hwrite,
    input  logic [2:0]                 hsize,
    input  logic                       hready,
    input  logic [NUM_REGS*DATA_W-1:0] reg_data,
    output logic [DATA_W-1:0]          hrdata,
    output logic                       hreadyout,
    output logic                       hresp,
    output logic [NUM_REGS-1:0]        rd_strobe
);

    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [SEL_W-1:0] dec_idx;
    logic             dec_err;
    logic [SEL_W-1:0] idx_q;
    logic [3:0]       cnt;
    logic             accept;
    ahb_slv_state_t   state;
    logic [DATA_W-1:0] words [NUM_REGS];

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            words[i] = reg_data[i*DATA_W +: DATA_W];
        end
    end

    ahb_access_check #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) u_check (
        .haddr  (haddr),
        .hwrite (hwrite),
        .hsize  (hsize),
        .idx    (dec_idx),
        .err    (dec_err)
    );

    assign accept = hsel & hready & htrans[1];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            idx_q     <= '0;
            hrdata    <= '0;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
            rd_strobe <= '0;
        end else begin
            rd_strobe <= '0;
            case (state)
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= ST_IDLE;
                        hreadyout <= 1'b1;
                        hrdata    <= words[idx_q];
                        rd_strobe <= NUM_REGS'(1) << idx_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_ERROR;
                end
                // IDLE and ERR2 both end with a cycle where a new address phase may be accepted
                default: begin
                    state     <= ST_IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_OKAY;
                    if (accept) begin
                        if (dec_err) begin
                            state     <= ST_ERR1;
                            hreadyout <= 1'b0;
                            hresp     <= HRESP_ERROR;
                        end else if (WAIT_STATES == 0) begin
                            hrdata    <= words[dec_idx];
                            rd_strobe <= NUM_REGS'(1) << dec_idx;
                        end else begin
                            state     <= ST_WAIT;
                            cnt       <= 4'(WAIT_STATES - 1);
                            idx_q     <= dec_idx;
                            hreadyout <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_read_slave.sv
// Directed bench: three slave instances (0, 1 and 3 wait states) on a shared bus.
module tb_ahb_read_slave;
    import ahb_pkg::*;

    logic         hclk = 1'b0;
    logic         hreset_n;
    logic         hsel0, hsel1, hsel3;
    logic [7:0]   haddr;
    logic [1:0]   htrans;
    logic         hwrite;
    logic [2:0]   hsize;
    logic         hready_en;
    logic         hready;
    logic [255:0] reg_data;

    logic [31:0] hrdata0, hrdata1, hrdata3;
    logic        ho0, ho1, ho3;
    logic        hr0, hr1, hr3;
    logic [7:0]  st0, st1, st3;

    int tests = 0;
    int fails = 0;

    always #5 hclk = ~hclk;

    // Bus-level ready: the idle slaves always report ready, so the AND acts as the mux.
    assign hready = hready_en & ho0 & ho1 & ho3;

    ahb_read_slave #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(8), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hready(hready), .reg_data(reg_data),
        .hrdata(hrdata0), .hreadyout(ho0), .hresp(hr0), .rd_strobe(st0));

    ahb_read_slave #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(8), .WAIT_STATES(1)) dut1 (
        .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hready(hready), .reg_data(reg_data),
        .hrdata(hrdata1), .hreadyout(ho1), .hresp(hr1), .rd_strobe(st1));

    ahb_read_slave #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(8), .WAIT_STATES(3)) dut3 (
        .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hready(hready), .reg_data(reg_data),
        .hrdata(hrdata3), .hreadyout(ho3), .hresp(hr3), .rd_strobe(st3));

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus(input logic s0, input logic s1, input logic s3, input htrans_t tr,
                       input logic [7:0] a, input logic w, input logic [2:0] sz);
        hsel0  = s0;
        hsel1  = s1;
        hsel3  = s3;
        htrans = tr;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 1'b0, HTRANS_IDLE, 8'h00, 1'b0, 3'd0);
    endtask

    task automatic err_seq(input string tag, input logic [7:0] a, input logic w,
                           input logic [2:0] sz, input logic [31:0] prev);
        bus(1'b0, 1'b1, 1'b0, HTRANS_NONSEQ, a, w, sz);
        tick();
        idle();
        check({tag, "_err1_ready"}, 32'(ho1), 32'd0);
        check({tag, "_err1_resp"}, 32'(hr1), 32'd1);
        check({tag, "_err1_strobe"}, 32'(st1), 32'd0);
        tick();
        check({tag, "_err2_ready"}, 32'(ho1), 32'd1);
        check({tag, "_err2_resp"}, 32'(hr1), 32'd1);
        check({tag, "_err2_strobe"}, 32'(st1), 32'd0);
        tick();
        check({tag, "_after_resp"}, 32'(hr1), 32'd0);
        check({tag, "_after_ready"}, 32'(ho1), 32'd1);
        check({tag, "_hrdata_held"}, hrdata1, prev);
    endtask

    initial begin
        hreset_n  = 1'b0;
        hready_en = 1'b1;
        idle();
        reg_data = '0;
        reg_data[0*32 +: 32] = 32'hA5A5_0001;
        reg_data[1*32 +: 32] = 32'hDEAD_BEEF;
        reg_data[2*32 +: 32] = 32'h1234_5678;
        reg_data[3*32 +: 32] = 32'h0BAD_F00D;
        reg_data[7*32 +: 32] = 32'h7777_7777;

        // Reset state
        tick();
        tick();
        check("rst_hrdata", hrdata1, 32'h0);
        check("rst_ready", 32'(ho1 & ho0 & ho3), 32'd1);
        check("rst_resp", 32'(hr1 | hr0 | hr3), 32'd0);
        check("rst_strobe", 32'(st1 | st0 | st3), 32'd0);
        @(negedge hclk);
        hreset_n = 1'b1;

        // Back-to-back reads, one wait state: 0x04 then 0x08
        bus(1'b0, 1'b1, 1'b0, HTRANS_NONSEQ, 8'h04, 1'b0, 3'd2);
        tick();
        bus(1'b0, 1'b1, 1'b0, HTRANS_NONSEQ, 8'h08, 1'b0, 3'd2);
        check("b2b_c1_ready", 32'(ho1), 32'd0);
        check("b2b_c1_strobe", 32'(st1), 32'd0);
        tick();
        check("b2b_c2_ready", 32'(ho1), 32'd1);
        check("b2b_c2_resp", 32'(hr1), 32'd0);
        check("b2b_c2_hrdata", hrdata1, 32'hDEAD_BEEF);
        check("b2b_c2_strobe", 32'(st1), 32'h02);
        tick();
        idle();
        check("b2b_c3_ready", 32'(ho1), 32'd0);
        check("b2b_c3_strobe", 32'(st1), 32'd0);
        check("b2b_c3_hrdata", hrdata1, 32'hDEAD_BEEF);
        tick();
        check("b2b_c4_ready", 32'(ho1), 32'd1);
        check("b2b_c4_hrdata", hrdata1, 32'h1234_5678);
        check("b2b_c4_strobe", 32'(st1), 32'h04);
        tick();
        check("b2b_c5_strobe", 32'(st1), 32'd0);
        check("b2b_c5_hrdata", hrdata1, 32'h1234_5678);

        // Zero-wait reads: 0x00, last word 0x1C, byte read at 0x0B
        bus(1'b1, 1'b0, 1'b0, HTRANS_NONSEQ, 8'h00, 1'b0, 3'd2);
        tick();
        check("zw_ready", 32'(ho0), 32'd1);
        check("zw_resp", 32'(hr0), 32'd0);
        check("zw_hrdata", hrdata0, 32'hA5A5_0001);
        check("zw_strobe", 32'(st0), 32'h01);
        bus(1'b1, 1'b0, 1'b0, HTRANS_SEQ, 8'h1C, 1'b0, 3'd2);
        tick();
        check("zw_last_hrdata", hrdata0, 32'h7777_7777);
        check("zw_last_strobe", 32'(st0), 32'h80);
        bus(1'b1, 1'b0, 1'b0, HTRANS_NONSEQ, 8'h0B, 1'b0, 3'd0);
        tick();
        idle();
        check("zw_byte_hrdata", hrdata0, 32'h1234_5678);
        check("zw_byte_strobe", 32'(st0), 32'h04);
        tick();
        check("zw_idle_strobe", 32'(st0), 32'd0);
        check("zw_idle_hrdata", hrdata0, 32'h1234_5678);

        // Error responses
        err_seq("write", 8'h00, 1'b1, 3'd2, 32'h1234_5678);
        err_seq("range", 8'h20, 1'b0, 3'd2, 32'h1234_5678);
        err_seq("oversize", 8'h00, 1'b0, 3'd3, 32'h1234_5678);
        err_seq("half_misalign", 8'h05, 1'b0, 3'd1, 32'h1234_5678);

        // Misaligned word read, then a read accepted at the end of ERR2
        bus(1'b0, 1'b1, 1'b0, HTRANS_NONSEQ, 8'h02, 1'b0, 3'd2);
        tick();
        bus(1'b0, 1'b1, 1'b0, HTRANS_NONSEQ, 8'h0C, 1'b0, 3'd2);
        check("mis_err1_resp", 32'(hr1), 32'd1);
        check("mis_err1_ready", 32'(ho1), 32'd0);
        tick();
        check("mis_err2_resp", 32'(hr1), 32'd1);
        check("mis_err2_ready", 32'(ho1), 32'd1);
        tick();
        idle();
        check("post_err_wait_ready", 32'(ho1), 32'd0);
        check("post_err_wait_resp", 32'(hr1), 32'd0);
        tick();
        check("post_err_hrdata", hrdata1, 32'h0BAD_F00D);
        check("post_err_strobe", 32'(st1), 32'h08);

        // IDLE, BUSY and stalled NONSEQ are all ignored
        bus(1'b0, 1'b1, 1'b0, HTRANS_IDLE, 8'h04, 1'b0, 3'd2);
        tick();
        check("idle_ready", 32'(ho1), 32'd1);
        check("idle_strobe", 32'(st1), 32'd0);
        bus(1'b0, 1'b1, 1'b0, HTRANS_BUSY, 8'h04, 1'b0, 3'd2);
        tick();
        check("busy_ready", 32'(ho1), 32'd1);
        check("busy_strobe", 32'(st1), 32'd0);
        hready_en = 1'b0;
        bus(1'b0, 1'b1, 1'b0, HTRANS_NONSEQ, 8'h04, 1'b0, 3'd2);
        tick();
        idle();
        hready_en = 1'b1;
        check("stall_ready", 32'(ho1), 32'd1);
        check("stall_resp", 32'(hr1), 32'd0);
        tick();
        check("stall_strobe", 32'(st1), 32'd0);
        check("stall_hrdata", hrdata1, 32'h0BAD_F00D);

        // Three wait states: full read of 0x08
        bus(1'b0, 1'b0, 1'b1, HTRANS_NONSEQ, 8'h08, 1'b0, 3'd2);
        tick();
        idle();
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("w3_c%0d_ready", c), 32'(ho3), 32'd0);
            tick();
        end
        check("w3_done_ready", 32'(ho3), 32'd1);
        check("w3_done_hrdata", hrdata3, 32'h1234_5678);
        check("w3_done_strobe", 32'(st3), 32'h04);
        tick();

        // Async reset asserted in cycle 2 of a wait
        bus(1'b0, 1'b0, 1'b1, HTRANS_NONSEQ, 8'h04, 1'b0, 3'd2);
        tick();
        idle();
        tick();
        check("mid_wait_ready", 32'(ho3), 32'd0);
        #2;
        hreset_n = 1'b0;
        #1;
        check("async_rst_hrdata", hrdata3, 32'h0);
        check("async_rst_ready", 32'(ho3), 32'd1);
        check("async_rst_resp", 32'(hr3), 32'd0);
        @(negedge hclk);
        hreset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("post_rst_strobe_%0d", c), 32'(st3), 32'd0);
            check($sformatf("post_rst_ready_%0d", c), 32'(ho3), 32'd1);
        end
        check("post_rst_hrdata", hrdata3, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_read_slave.md
# ahb_read_slave

Parametrised AHB-Lite read-only slave presenting `NUM_REGS` status words of `DATA_W` bits to the bus. It runs a proper address/data-phase pipeline with configurable wait states. Illegal accesses (writes, out-of-range index, oversize or misaligned transfers) get the two-cycle AHB ERROR response. A per-register read strobe supports clear-on-read logic in the owning block. It sits behind the AHB decoder/mux, like the existing single-byte read slave it replaces.

## Interface
Parameters:
- `DATA_W`, 32, bus data width; 8, 16 or 32.
- `ADDR_W`, 8, width of the `haddr` slice seen by the slave.
- `NUM_REGS`, 8, number of readable words; 1..2^(`ADDR_W`-log2(`DATA_W`/8)).
- `WAIT_STATES`, 1, data-phase wait cycles on OKAY reads; 0..15.

Ports:
- `hclk`  in  1  clock
- `hreset_n`  in  1  reset; asynchronous, active-low
- `hsel`  in  1  slave select (address phase)
- `haddr`  in  `ADDR_W`  byte address
- `htrans`  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- `hwrite`  in  1  write flag
- `hsize`  in  3  log2 transfer bytes
- `hready`  in  1  bus-level ready from mux
- `reg_data`  in  `NUM_REGS`*`DATA_W`  flattened status words, word i at [i*`DATA_W` +: `DATA_W`]
- `hrdata`  out  `DATA_W`  read data
- `hreadyout`  out  1  slave ready
- `hresp`  out  1  0=OKAY, 1=ERROR
- `rd_strobe`  out  `NUM_REGS`  one-hot pulse, word read completed

## Operation
- **Accept condition:** `hsel` && `hready` && `htrans`[1] at a rising edge. IDLE/BUSY or unselected cycles are ignored. The slave gives a zero-wait OKAY with no state change.
- **Decode at accept:**
  - idx = `haddr` >> log2(`DATA_W`/8).
  - err = `hwrite` | (idx ≥ `NUM_REGS`) | (`hsize` > log2(`DATA_W`/8)) | (`haddr` not aligned to 2^`hsize`).
- **FSM states:** IDLE, WAIT, ERR1, ERR2.
  - IDLE, accept, err → ERR1.
  - IDLE, accept, !err, `WAIT_STATES`=0 → stay IDLE. The completing data cycle is the next cycle.
  - IDLE, accept, !err, `WAIT_STATES`>0 → WAIT, counter = `WAIT_STATES`-1.
  - WAIT: `hreadyout`=0. Decrement the counter each cycle. At counter 0, return to IDLE; the next cycle is the completing cycle.
  - ERR1: `hreadyout`=0, `hresp`=1 → ERR2.
  - ERR2: `hreadyout`=1, `hresp`=1 → IDLE. A new accept at the end of ERR2 is handled as from IDLE.
- **Completing cycle:** `hreadyout`=1, `hresp`=0. `hrdata` = word idx, sampled from `reg_data` at the edge that starts this cycle. `rd_strobe`[idx]=1 for exactly this cycle.
- **Pipelining:** an accept at the edge ending a completing or ERR2 cycle starts the next transfer back-to-back with no bubble.
- **Errored transfers:** no wait states are inserted, and `rd_strobe` never fires.
- **`hrdata` hold rule:** holds its last value outside completing cycles. It is never updated on errors.
- **Reset:** `hreset_n` low at any time, including mid-WAIT or mid-ERR1, forces:
  - state IDLE, counter 0
  - `hrdata`=0, `hreadyout`=1, `hresp`=0, `rd_strobe`=0
  
  The in-flight transfer is dropped.

## Timing
- Accept edge T0. OKAY read: `hreadyout`=0 during cycles 1..`WAIT_STATES`. Cycle `WAIT_STATES`+1 is the completing cycle.
- Error: cycle 1 is ERR1 (`hreadyout`=0, `hresp`=1). Cycle 2 is ERR2 (`hreadyout`=1, `hresp`=1).
- `hresp` is 1 only in ERR1/ERR2. `hreadyout` is 1 in IDLE.
- All outputs are registered; there is no combinational path from bus inputs to outputs.
- Counter width is 4 bits; arithmetic is unsigned with no wrap (it stops at 0).

## Structure
- Shared package `ahb_pkg`:
  - `htrans_t` enum (IDLE/BUSY/NONSEQ/SEQ)
  - `HRESP_OKAY`/`HRESP_ERROR` constants
  - slave state enum `ahb_slv_state_t` (IDLE/WAIT/ERR1/ERR2)
- Sub-module `ahb_access_check`: combinational decode of `haddr`/`hsize`/`hwrite` into idx and err, parametrised by `DATA_W`, `ADDR_W`, `NUM_REGS`. The FSM, counter and output registers stay in the top.

## Test plan
- **Reset, then back-to-back NONSEQ reads** (`DATA_W`=32, `WAIT_STATES`=1), reg1=0xDEADBEEF, reg2=0x12345678, at 0x04 then 0x08:
  - `hreadyout` pattern 0,1,0,1.
  - `hrdata` 0xDEADBEEF, then 0x12345678.
  - `rd_strobe` 0x02, then 0x04, one cycle each.
- **Zero-wait config, `WAIT_STATES`=0, read 0x00:** completes the cycle after accept with `hreadyout`=1, `hresp`=0.
- **Write to 0x00:**
  - ERR1 (`hreadyout`=0, `hresp`=1), then ERR2 (`hreadyout`=1, `hresp`=1).
  - `hrdata` unchanged; `rd_strobe`=0.
- **Bad accesses (ERROR response each):**
  - Out-of-range: read 0x20 with `NUM_REGS`=8.
  - Misaligned: `hsize`=2 at 0x02.
  - Oversize: `hsize`=3.
- **IDLE/BUSY while `hsel`=1, and NONSEQ with `hready`=0:** no state change; `hreadyout` stays 1.
- **Async reset mid-WAIT** (`WAIT_STATES`=3, reset asserted in cycle 2):
  - Outputs return immediately to `hrdata`=0, `hreadyout`=1, `hresp`=0.
  - No `rd_strobe` after release.
